// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-ported integer register file with an integrated write scoreboard.
//   Register 0 is hardwired to zero and is never busy. Reads are
//   combinational; writes, scoreboard updates and the collision flag update
//   on the rising clock edge.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - when defined, each read port forwards same-cycle write
//                       data (highest-index matching write port wins) and
//                       masks rd_busy for a forwarded address unless a
//                       same-cycle reserve targets it.
//
// Ports:
//   clk          in   clock, rising-edge active
//   rst          in   synchronous active-high reset
//   rd_addr      in   NUM_RD read addresses, port i at [i*AW +: AW]
//   rd_data      out  NUM_RD read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy      out  scoreboard busy bit of the register read by port i
//   wr_en        in   per-port write enable
//   wr_addr      in   NUM_WR write addresses, packed like rd_addr
//   wr_data      in   NUM_WR write data, packed like rd_data
//   rsv_en       in   reserve request for rsv_addr
//   rsv_addr     in   register to mark pending-write
//   busy_vec     out  full scoreboard state, bit r = register r pending
//   wr_collision out  set for the cycle after a same-address write conflict
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     wr_collision
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_wr_coll;

  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_rsv_hit;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_coll;

  // ---------------------------------------------------------------------------
  // Decoded write / reserve targets (address 0 excluded)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_hit = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        w_wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_rsv_hit = '0;
    if (rsv_en && (rsv_addr != '0)) begin
      w_rsv_hit[rsv_addr] = 1'b1;
    end
  end

  // Reserve has priority over a same-cycle clearing write.
  always_comb begin
    w_busy_nxt    = (r_busy & ~w_wr_hit) | w_rsv_hit;
    w_busy_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Same-address conflict detection between any pair of enabled ports
  // ---------------------------------------------------------------------------
  always_comb begin
    w_coll = 1'b0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      for (int unsigned k = j + 1; k < NUM_WR; k++) begin
        if (wr_en[j] && wr_en[k] &&
            (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW]) &&
            (wr_addr[j*AW +: AW] != '0)) begin
          w_coll = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State update. Ports are applied in ascending order so the highest-index
  // port's nonblocking assignment is the one that lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy    <= '0;
      r_wr_coll <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
      r_busy    <= w_busy_nxt;
      r_wr_coll <= w_coll;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]     w_a;
      logic [DATA_W-1:0] w_d;
      logic              w_b;
      w_a = rd_addr[i*AW +: AW];
      w_d = (w_a == '0) ? '0 : r_regs[w_a];
      w_b = r_busy[w_a];
`ifdef REGFILE_BYPASS_EN
      begin : g_fwd
        logic w_fwd;
        w_fwd = 1'b0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == w_a) && (w_a != '0)) begin
            w_d   = wr_data[j*DATA_W +: DATA_W];
            w_fwd = 1'b1;
          end
        end
        // A forwarded write retires the pending value unless a younger
        // reserve to the same register arrives in this cycle.
        if (w_fwd && !(rsv_en && (rsv_addr == w_a))) begin
          w_b = 1'b0;
        end
      end
`endif
      rd_data[i*DATA_W +: DATA_W] = w_d;
      rd_busy[i]                  = w_b;
    end
  end

  assign busy_vec     = r_busy;
  assign wr_collision = r_wr_coll;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
//   Self-checking bench for regfile_mp_sb (default parameters). Directed
//   scenarios followed by randomized traffic checked against an array-based
//   reference model of the register file and scoreboard.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [NR-1:0]     busy_vec;
  logic              wr_collision;

  regfile_mp_sb #(
    .DATA_W  (DW),
    .NUM_REGS(NR),
    .NUM_RD  (NRD),
    .NUM_WR  (NWR)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .busy_vec    (busy_vec),
    .wr_collision(wr_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_coll;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned wa(input int unsigned j);
    logic [NWR*AW-1:0] v;
    v = wr_addr;
    return int'(v[j*AW +: AW]);
  endfunction

  function automatic int unsigned ra(input int unsigned i);
    logic [NRD*AW-1:0] v;
    v = rd_addr;
    return int'(v[i*AW +: AW]);
  endfunction

  // Apply the effect of the current inputs at the coming edge to the model.
  task automatic model_step();
    logic coll;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_busy = '0;
      m_coll = 1'b0;
    end else begin
      coll = 1'b0;
      for (int j = 0; j < NWR; j++)
        for (int k = 0; k < NWR; k++)
          if (j != k && wr_en[j] && wr_en[k] && wa(j) == wa(k) && wa(j) != 0)
            coll = 1'b1;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wa(j) != 0) begin
          m_regs[wa(j)] = wr_data[j*DW +: DW];
          m_busy[wa(j)] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      m_coll = coll;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 0; rsv_addr = '0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  // Compare all outputs against the model for the current inputs.
  task automatic check_outputs(input string tag);
    int unsigned   a;
    logic [DW-1:0] ed;
    logic          eb;
    logic          fwd;
    for (int i = 0; i < NRD; i++) begin
      a   = ra(i);
      ed  = (a == 0) ? '0 : m_regs[a];
      eb  = (a == 0) ? 1'b0 : m_busy[a];
      fwd = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wa(j) == a && a != 0) begin
          ed  = wr_data[j*DW +: DW];
          fwd = 1'b1;
        end
      if (fwd && !(rsv_en && rsv_addr == a)) eb = 1'b0;
`endif
      check($sformatf("%s_rd_data%0d", tag, i), 64'(rd_data[i*DW +: DW]), 64'(ed));
      check($sformatf("%s_rd_busy%0d", tag, i), 64'(rd_busy[i]), 64'(eb));
    end
    check({tag, "_busy_vec"}, 64'(busy_vec), 64'(m_busy));
    check({tag, "_wr_coll"}, 64'(wr_collision), 64'(m_coll));
  endtask

  initial begin
    rd_addr = '0;
    idle();
    for (int r = 0; r < NR; r++) m_regs[r] = 'x;
    m_busy = 'x;
    m_coll = 1'bx;

    // 1. Reset, sweep all addresses
    rst = 1;
    step();
    idle();
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a); set_rd(1, a);
      #1;
      check("rst_rd0", 64'(rd_data[0 +: DW]), 64'h0);
      check("rst_rd1", 64'(rd_data[DW +: DW]), 64'h0);
      check("rst_busy", 64'(rd_busy), 64'h0);
    end
    check("rst_busy_vec", 64'(busy_vec), 64'h0);
    check("rst_coll", 64'(wr_collision), 64'h0);

    // 2. Write r5, write to r0 ignored
    set_wr(0, 5, 32'hDEADBEEF);
    set_wr(1, 0, 32'h12345678);
    step();
    idle();
    set_rd(0, 5); set_rd(1, 0);
    #1;
    check("t2_r5", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    check("t2_r0", 64'(rd_data[DW +: DW]), 64'h0);
    check("t2_coll", 64'(wr_collision), 64'h0);

    // 3. Same-address conflict: port1 wins, flag for one cycle
    set_wr(0, 7, 32'h1111);
    set_wr(1, 7, 32'h2222);
    step();
    idle();
    set_rd(0, 7);
    #1;
    check("t3_r7", 64'(rd_data[0 +: DW]), 64'h2222);
    check("t3_coll_set", 64'(wr_collision), 64'h1);
    step();
    check("t3_coll_clr", 64'(wr_collision), 64'h0);

    // 4. Scoreboard reserve / write interaction
    rsv_en = 1; rsv_addr = 9;
    step();
    idle();
    set_rd(0, 9);
    #1;
    check("t4_busy9", 64'(busy_vec[9]), 64'h1);
    check("t4_rd_busy", 64'(rd_busy[0]), 64'h1);
    rsv_en = 1; rsv_addr = 9;
    set_wr(1, 9, 32'h99);
    step();
    idle();
    check("t4_rsv_wins", 64'(busy_vec[9]), 64'h1);
    set_wr(0, 9, 32'h98);
    step();
    idle();
    check("t4_wr_clears", 64'(busy_vec[9]), 64'h0);

    // 5. Reset overrides writes and reserves
    rst = 1;
    set_wr(0, 3, 32'hA5A5A5A5);
    step();
    idle();
    set_rd(0, 3);
    #1;
    check("t5_r3", 64'(rd_data[0 +: DW]), 64'h0);
    rsv_en = 1; rsv_addr = 4;
    step();
    idle();
    check("t5_busy4_set", 64'(busy_vec[4]), 64'h1);
    rst = 1;
    step();
    idle();
    check("t5_busy4_rst", 64'(busy_vec[4]), 64'h0);

    // 6. Same-cycle read of a register being written
    set_wr(1, 12, 32'h1234);
    step();
    idle();
    set_wr(0, 12, 32'hCAFE);
    set_rd(0, 12);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t6_same_cycle", 64'(rd_data[0 +: DW]), 64'hCAFE);
`else
    check("t6_same_cycle", 64'(rd_data[0 +: DW]), 64'h1234);
`endif
    check_outputs("t6_model");
    step();
    idle();
    #1;
    check("t6_next_cycle", 64'(rd_data[0 +: DW]), 64'hCAFE);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 59) == 0);
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, NR - 1));
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = ($urandom_range(0, 1) == 1);
        wr_addr[j*AW +: AW] = AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                                               : $urandom_range(0, NR - 1));
        wr_data[j*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NRD; i++) begin
        if ($urandom_range(0, 2) == 0 && wr_en[0])
          rd_addr[i*AW +: AW] = wr_addr[0 +: AW];
        else if ($urandom_range(0, 1) == 0)
          rd_addr[i*AW +: AW] = rsv_addr;
        else
          rd_addr[i*AW +: AW] = AW'($urandom_range(0, NR - 1));
      end
      #1;
      check_outputs("rand");
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Multi-ported, parametrised integer register file for the pipelined datapath. It provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports, with register 0 hardwired to zero. An integrated scoreboard tracks registers that have a pending write. The decode stage uses it to detect RAW hazards, and the writeback and load-return paths write through it.

Parameters:
DATA_W, 32, width of each register in bits
NUM_REGS, 32, number of architectural registers; power of two, minimum 2
NUM_RD, 2, number of read ports, minimum 1
NUM_WR, 2, number of write ports, minimum 1
AW (localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous and active-high
rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  scoreboard busy bit of the register addressed by port i
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses, packed as rd_addr
wr_data  in  NUM_WR*DATA_W  write data, packed as rd_data
rsv_en  in  1  reserve request: mark rsv_addr as pending-write
rsv_addr  in  AW  register to reserve
busy_vec  out  NUM_REGS  full scoreboard state; bit r = register r pending
wr_collision  out  1  registered flag: a same-address write conflict occurred in the previous cycle

Behaviour:
- Reset: while rst=1 at a rising edge, all registers, busy_vec and wr_collision clear to 0 on that edge. rst overrides every write, reserve and collision event in the same cycle. After reset, rd_data=0, rd_busy=0 and busy_vec=0 on every port.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reserves to address 0 are ignored.
  - Writes to address 0 never count toward wr_collision.
- Read: rd_data[i] is a combinational function of rd_addr[i] and current register state, with zero cycle latency. rd_busy[i] = busy_vec[rd_addr[i]], also combinational.
- Write: if wr_en[j]=1 and wr_addr[j]!=0, register[wr_addr[j]] takes wr_data[j] at the rising edge. Without bypass, the new value is visible on reads in the cycle after the edge.
- Write priority: when several enabled ports target the same nonzero address, the highest-index port wins.
- Collision flag: wr_collision is set to 1 for exactly the cycle after any such same-address conflict, otherwise 0. It is a diagnostic only.
- Scoreboard, per register r != 0:
  - Set busy_vec[r] when rsv_en=1 and rsv_addr=r.
  - Otherwise clear busy_vec[r] when any enabled write port targets r.
  - Otherwise hold.
- Simultaneous reserve and write to the same register in one cycle: the reserve wins and busy stays 1. This models an older instruction retiring while a younger one reserves the same destination.
- Reserving an already-busy register keeps it busy; there is no counting. The first write clears it.
- A write to a non-busy register is legal and leaves busy at 0.
- No internal FSM beyond the register state, scoreboard and collision flag. All outputs are defined in every cycle.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - Each read port forwards same-cycle write data. If any wr_en[j]=1 with wr_addr[j]=rd_addr[i]!=0, rd_data[i] returns the highest-index such wr_data[j]; otherwise it returns the stored value.
  - rd_busy[i] is forced to 0 when such a matching write exists and no same-cycle reserve targets that address.
- Undefined: reads return stored contents only. A write becomes visible the cycle after its edge. rd_busy reflects busy_vec only.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_vec=0, wr_collision=0.
2. Port0 writes 0xDEADBEEF to r5, and port1 writes 0x12345678 to r0, in the same cycle -> next cycle rd_addr0=5 reads 0xDEADBEEF and rd_addr1=0 reads 0; wr_collision=0.
3. Port0 writes 0x1111 and port1 writes 0x2222 to r7 in the same cycle -> next cycle r7 reads 0x2222 and wr_collision=1; one cycle later wr_collision=0.
4. Reserve r9 -> busy_vec[9]=1 and rd_busy=1 when reading r9. Reserve r9 while port1 writes r9 -> busy stays 1. Next cycle, write r9 with no reserve -> busy_vec[9]=0.
5. Write r3=0xA5A5A5A5 with rst=1 asserted in that cycle -> r3 reads 0 afterwards. Reserve r4, then assert rst -> busy_vec[4]=0.
6. With REGFILE_BYPASS_EN: write r12=0xCAFE while port0 reads r12 in the same cycle -> rd_data0=0xCAFE combinationally. Without the macro -> old value in that cycle, 0xCAFE the next cycle.
